// File: rtl/bus_xfer_ctrl.sv
// Register/RAM bus sequencer: MOVE, STORE, LOAD and SWAP commands,
// one internal bus transfer per cycle.
module bus_xfer_ctrl #(
    parameter int W     = 4,
    parameter int NREG  = 4,
    parameter int DEPTH = 16,
    parameter int RW    = $clog2(NREG),
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [RW-1:0]     cmd_src,
    input  logic [RW-1:0]     cmd_dst,
    input  logic [AW-1:0]     cmd_addr,
    input  logic              ext_we,
    input  logic [RW-1:0]     ext_idx,
    input  logic [W-1:0]      ext_data,
    output logic              busy,
    output logic              done,
    output logic [W-1:0]      bus_data,
    output logic [NREG*W-1:0] reg_q,
    input  logic [AW-1:0]     mon_addr,
    output logic [W-1:0]      mon_data
);

    typedef enum logic [1:0] {IDLE, X1, X2, X3} state_t;
    typedef enum logic [1:0] {
        OP_MOVE, OP_STORE, OP_LOAD, OP_SWAP
    } op_t;

    state_t          state;
    op_t             op_q;
    logic [RW-1:0]   src_q;
    logic [RW-1:0]   dst_q;
    logic [AW-1:0]   addr_q;
    logic [W-1:0]    tmp;
    logic [W-1:0]    bus;
    logic [W-1:0]    regs [NREG];
    logic [W-1:0]    mem  [DEPTH];

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign bus_data  = bus;
    assign mon_data  = mem[mon_addr];

    for (genvar g = 0; g < NREG; g++) begin : g_q
        assign reg_q[g*W +: W] = regs[g];
    end

    // SWAP reuses src as operand A and dst as operand B
    always_comb begin
        bus = '0;
        unique case (state)
            IDLE: bus = '0;
            X1:   bus = (op_q == OP_LOAD) ? mem[addr_q] : regs[src_q];
            X2:   bus = regs[dst_q];
            X3:   bus = tmp;
        endcase
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state  <= IDLE;
            op_q   <= OP_MOVE;
            src_q  <= '0;
            dst_q  <= '0;
            addr_q <= '0;
            tmp    <= '0;
            done   <= 1'b0;
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (ext_we) regs[ext_idx] <= ext_data;
                    if (cmd_valid) begin
                        op_q   <= op_t'(cmd_op);
                        src_q  <= cmd_src;
                        dst_q  <= cmd_dst;
                        addr_q <= cmd_addr;
                        state  <= X1;
                    end
                end
                X1: begin
                    if (op_q == OP_SWAP) begin
                        tmp   <= bus;
                        state <= X2;
                    end else begin
                        if (op_q != OP_STORE) regs[dst_q] <= bus;
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                X2: begin
                    regs[src_q] <= bus;
                    state       <= X3;
                end
                X3: begin
                    regs[dst_q] <= bus;
                    done        <= 1'b1;
                    state       <= IDLE;
                end
            endcase
        end
    end

    // RAM contents survive reset
    always_ff @(posedge clk) begin
        if (state == X1 && op_q == OP_STORE) mem[addr_q] <= bus;
    end

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Bench for bus_xfer_ctrl: directed scenarios then random commands
// against a transaction-level register/RAM model.
module tb_bus_xfer_ctrl;

    localparam int W = 4, NREG = 4, DEPTH = 16;
    localparam int RW = 2, AW = 4;

    logic              clk = 1'b0;
    logic              clr_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [1:0]        cmd_op;
    logic [RW-1:0]     cmd_src, cmd_dst;
    logic [AW-1:0]     cmd_addr;
    logic              ext_we;
    logic [RW-1:0]     ext_idx;
    logic [W-1:0]      ext_data;
    logic              busy, done;
    logic [W-1:0]      bus_data;
    logic [NREG*W-1:0] reg_q;
    logic [AW-1:0]     mon_addr;
    logic [W-1:0]      mon_data;

    bus_xfer_ctrl #(.W(W), .NREG(NREG), .DEPTH(DEPTH)) dut (
        .clk(clk), .clr_n(clr_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_src(cmd_src), .cmd_dst(cmd_dst),
        .cmd_addr(cmd_addr),
        .ext_we(ext_we), .ext_idx(ext_idx), .ext_data(ext_data),
        .busy(busy), .done(done), .bus_data(bus_data),
        .reg_q(reg_q), .mon_addr(mon_addr), .mon_data(mon_data)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    logic [W-1:0] mregs [NREG];
    logic [W-1:0] mmem  [DEPTH];
    bit           mval  [DEPTH];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs();
        for (int i = 0; i < NREG; i++)
            chk($sformatf("reg%0d", i), 32'(reg_q[i*W +: W]), 32'(mregs[i]));
    endtask

    task automatic check_mon(input int a);
        mon_addr = AW'(a);
        #1;
        chk($sformatf("mem%0d", a), 32'(mon_data), 32'(mmem[a]));
    endtask

    task automatic ext_wr(input int idx, input int data);
        chk("ext_ready", 32'(cmd_ready), 1);
        ext_we   = 1'b1;
        ext_idx  = RW'(idx);
        ext_data = W'(data);
        mregs[idx] = W'(data);
        step();
        ext_we = 1'b0;
        chk("ext_done_low", 32'(done), 0);
        check_regs();
    endtask

    // Drives one command from an IDLE cycle and follows it to its done cycle.
    task automatic do_cmd(input int op, input int src, input int dst,
                          input int addr, input bit ew, input int eidx,
                          input int edata, input bit noise);
        logic [W-1:0] q[$];
        chk("accept_ready", 32'(cmd_ready), 1);
        if (ew) begin
            ext_we   = 1'b1;
            ext_idx  = RW'(eidx);
            ext_data = W'(edata);
            mregs[eidx] = W'(edata);
        end
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_src   = RW'(src);
        cmd_dst   = RW'(dst);
        cmd_addr  = AW'(addr);
        case (op)
            2:       q = {mmem[addr]};
            3:       q = {mregs[src], mregs[dst], mregs[src]};
            default: q = {mregs[src]};
        endcase
        step();
        cmd_valid = 1'b0;
        cmd_op    = 2'($urandom);
        cmd_src   = RW'($urandom);
        cmd_dst   = RW'($urandom);
        cmd_addr  = AW'($urandom);
        ext_we    = 1'b0;
        foreach (q[i]) begin
            chk("busy", 32'(busy), 1);
            chk("ready_busy", 32'(cmd_ready), 0);
            chk("done_busy", 32'(done), 0);
            chk($sformatf("bus_x%0d", i + 1), 32'(bus_data), 32'(q[i]));
            if (noise) begin
                ext_we   = 1'b1;
                ext_idx  = RW'($urandom);
                ext_data = W'($urandom);
            end
            step();
            ext_we = 1'b0;
        end
        chk("done_pulse", 32'(done), 1);
        chk("busy_end", 32'(busy), 0);
        chk("ready_end", 32'(cmd_ready), 1);
        chk("bus_idle", 32'(bus_data), 0);
        case (op)
            0, 2: mregs[dst] = q[0];
            1: begin
                mmem[addr] = q[0];
                mval[addr] = 1'b1;
            end
            default: begin
                mregs[src] = q[1];
                mregs[dst] = q[0];
            end
        endcase
        check_regs();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            step();
            chk("idle_done", 32'(done), 0);
            chk("idle_busy", 32'(busy), 0);
        end
    endtask

    initial begin
        clr_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = '0;
        cmd_src   = '0;
        cmd_dst   = '0;
        cmd_addr  = '0;
        ext_we    = 1'b0;
        ext_idx   = '0;
        ext_data  = '0;
        mon_addr  = '0;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mmem[i] = '0;
            mval[i] = 1'b0;
        end

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(cmd_ready), 1);
        chk("rst_done", 32'(done), 0);
        chk("rst_bus", 32'(bus_data), 0);
        check_regs();
        #2 clr_n = 1'b1;
        step();

        ext_wr(0, 5);
        ext_wr(1, 9);
        do_cmd(3, 0, 1, 0, 0, 0, 0, 0);
        chk("swap_r0", 32'(reg_q[3:0]), 9);
        chk("swap_r1", 32'(reg_q[7:4]), 5);
        idle(1);

        // back-to-back chain, each accepted in the previous done cycle
        do_cmd(0, 0, 2, 0, 0, 0, 0, 0);
        do_cmd(1, 0, 0, 0, 0, 0, 0, 0);
        do_cmd(1, 1, 0, 1, 0, 0, 0, 0);
        do_cmd(2, 0, 3, 0, 0, 0, 0, 0);
        chk("load_r3", 32'(reg_q[15:12]), 9);
        mon_addr = '0;
        #1 chk("mon0", 32'(mon_data), 9);
        mon_addr = 4'd1;
        #1 chk("mon1", 32'(mon_data), 5);

        do_cmd(3, 2, 3, 0, 0, 0, 0, 1);
        do_cmd(3, 1, 1, 0, 0, 0, 0, 1);
        do_cmd(0, 0, 1, 0, 1, 0, 3, 0);
        chk("ext_move_r1", 32'(reg_q[7:4]), 3);
        do_cmd(0, 2, 2, 0, 0, 0, 0, 1);
        idle(2);

        // reset during SWAP X2
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_src   = 2'd0;
        cmd_dst   = 2'd1;
        step();
        cmd_valid = 1'b0;
        step();
        #2 clr_n = 1'b0;
        #1;
        for (int i = 0; i < NREG; i++) mregs[i] = '0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_ready", 32'(cmd_ready), 1);
        chk("abort_bus", 32'(bus_data), 0);
        check_regs();
        mon_addr = '0;
        #1 chk("abort_mem0", 32'(mon_data), 9);
        #1 clr_n = 1'b1;
        step();
        check_regs();

        for (int n = 0; n < 80; n++) begin
            int op, a;
            op = int'($urandom_range(0, 3));
            a  = int'($urandom_range(0, DEPTH - 1));
            if (op == 2 && !mval[a]) op = 1;
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            if ($urandom_range(0, 4) == 0)
                ext_wr(int'($urandom_range(0, NREG - 1)), int'($urandom));
            do_cmd(op, int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, NREG - 1)), a,
                   bit'($urandom_range(0, 1)),
                   int'($urandom_range(0, NREG - 1)),
                   int'($urandom_range(0, 15)),
                   bit'($urandom_range(0, 1)));
            for (int k = 0; k < DEPTH; k++) begin
                if (mval[k] && $urandom_range(0, 7) == 0) check_mon(k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
